// File: rtl/gate_seq_pkg.sv
// Shared definitions for the gate equivalence sequencer.
package gate_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/gate_equiv_sequencer_vec_counter.sv
// Stimulus vector counter: clears to 0, counts up, holds at all-ones.
module vec_counter #(
  parameter int unsigned N_IN = 2
) (
  input  logic            clk,
  input  logic            clear,
  input  logic            enable,
  output logic [N_IN-1:0] vec,
  output logic            last
);

  // Flags the final vector of the sweep.
  always_comb begin
    last = &vec;
  end

  // Clear has priority; counting stops at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (clear) begin
      vec <= '0;
    end else if (enable && !last) begin
      vec <= vec + N_IN'(1);
    end
  end

endmodule

// File: rtl/gate_equiv_sequencer.sv
// Exhaustive sweep controller comparing two 1-bit gate implementations.
module gate_equiv_sequencer
  import gate_seq_pkg::*;
#(
  parameter int unsigned N_IN = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [N_IN-1:0] vec,
  input  logic            res_a,
  input  logic            res_b,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   mismatch_count,
  output logic            first_fail_valid,
  output logic [N_IN-1:0] first_fail_vec
);

  seq_state_t    state;
  logic          start_accept;
  logic          cnt_clear;
  logic          cnt_enable;
  logic          last;
  logic          mis;
  logic [N_IN:0] count_next;

  // Sweep bookkeeping: start acceptance, counter control, running mismatch total.
  always_comb begin
    start_accept = start && ((state == ST_IDLE) || (state == ST_DONE));
    cnt_clear    = reset || start_accept;
    cnt_enable   = (state == ST_RUN);
    mis          = res_a ^ res_b;
    count_next   = mismatch_count + {{N_IN{1'b0}}, mis};
  end

  vec_counter #(
    .N_IN(N_IN)
  ) u_vec_counter (
    .clk    (clk),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .vec    (vec),
    .last   (last)
  );

  // Sequencer FSM with registered status outputs and result accumulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      mismatch_count   <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            state            <= ST_RUN;
            busy             <= 1'b1;
            pass             <= 1'b0;
            mismatch_count   <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          mismatch_count <= count_next;
          if (mis && !first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_vec   <= vec;
          end
          if (last) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (count_next == '0);
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
